// File: rtl/pyramid_scan_ctrl.sv
// rtl/pyramid_scan_ctrl.sv - image pyramid level sequencer and sliding-window scan controller

`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 3
`endif
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd20, 32'd25, 32'd26}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd30, 32'd24, 32'd25}
`endif

module pyramid_scan_ctrl #(
  parameter int NUM_LEVELS = `PYRAMID_LEVELS,
  parameter logic [NUM_LEVELS-1:0][31:0] LEVEL_WIDTHS = `PYRAMID_WIDTHS,
  parameter logic [NUM_LEVELS-1:0][31:0] LEVEL_HEIGHTS = `PYRAMID_HEIGHTS,
  parameter int WIN_SIZE = 24,
  parameter int COORD_W = 9,
  parameter int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [LVL_W-1:0]   level,
  output logic               level_start,
  input  logic               level_ready,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t             state;
  logic               skip;
  logic [COORD_W-1:0] col_max;
  logic [COORD_W-1:0] row_max;
  logic               at_last_win;
  logic               last_level;
  logic               advance;
  logic [LVL_W-1:0]   next_level;

  // A level is worth loading only if at least one full window fits inside it
  function automatic logic fits(input logic [LVL_W-1:0] l);
    return (LEVEL_WIDTHS[l] >= 32'(WIN_SIZE)) && (LEVEL_HEIGHTS[l] >= 32'(WIN_SIZE));
  endfunction

  // Scan bounds of the current level and the level-advance condition
  always_comb begin
    col_max     = COORD_W'(LEVEL_WIDTHS[level] - 32'(WIN_SIZE));
    row_max     = COORD_W'(LEVEL_HEIGHTS[level] - 32'(WIN_SIZE));
    at_last_win = (win_col == col_max) && (win_row == row_max);
    last_level  = (level == LVL_W'(NUM_LEVELS - 1));
    next_level  = level + 1'b1;
    advance     = ((state == LOAD) && skip) ||
                  ((state == SCAN) && win_ready && at_last_win);
  end

  // Frame/level/window sequencer; every output is a register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      level       <= '0;
      win_row     <= '0;
      win_col     <= '0;
      skip        <= 1'b0;
      level_start <= 1'b0;
      win_valid   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_ready <= 1'b1;
    end else begin
      level_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid && frame_ready) begin
            state       <= LOAD;
            level       <= '0;
            win_row     <= '0;
            win_col     <= '0;
            frame_ready <= 1'b0;
            busy        <= 1'b1;
            level_start <= fits('0);
            skip        <= !fits('0);
          end
        end
        LOAD: begin
          // The strobe cycle itself never counts as ready: the unit has not started yet
          if (!skip && !level_start && level_ready) begin
            state     <= SCAN;
            win_valid <= 1'b1;
            win_row   <= '0;
            win_col   <= '0;
          end
        end
        SCAN: begin
          if (win_ready && !at_last_win) begin
            if (win_col < col_max) begin
              win_col <= win_col + 1'b1;
            end else begin
              win_col <= '0;
              win_row <= win_row + 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          frame_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Leaving a level (finished or skipped): next level, or end of frame
      if (advance) begin
        win_valid <= 1'b0;
        win_row   <= '0;
        win_col   <= '0;
        if (last_level) begin
          state      <= DONE;
          skip       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          state       <= LOAD;
          level       <= next_level;
          level_start <= fits(next_level);
          skip        <= !fits(next_level);
        end
      end
    end
  end

endmodule

// File: tb/tb_pyramid_scan_ctrl.sv
// tb/tb_pyramid_scan_ctrl.sv - directed self-checking bench for pyramid_scan_ctrl

module tb_pyramid_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       frame_valid, frame_ready, level_start, level_ready;
  logic       win_valid, win_ready, frame_done, busy;
  logic [1:0] level;
  logic [8:0] win_row, win_col;

  logic       fv2, fr2, ls2, lr2, wv2, wr2, fd2, busy2;
  logic [0:0] lvl2;
  logic [8:0] row2, col2;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wq[$];
  logic [31:0] exp_win[8];
  int ls_cnt, first_wv, lr_cnt, lr_delay, gcyc, done_cyc;
  bit bp_mode;

  pyramid_scan_ctrl #(
    .NUM_LEVELS(3),
    .LEVEL_WIDTHS({32'd20, 32'd25, 32'd26}),
    .LEVEL_HEIGHTS({32'd30, 32'd24, 32'd25}),
    .WIN_SIZE(24), .COORD_W(9), .LVL_W(2)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .level(level), .level_start(level_start), .level_ready(level_ready),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done), .busy(busy)
  );

  pyramid_scan_ctrl #(
    .NUM_LEVELS(2),
    .LEVEL_WIDTHS({32'd8, 32'd10}),
    .LEVEL_HEIGHTS({32'd8, 32'd10}),
    .WIN_SIZE(24), .COORD_W(9), .LVL_W(1)
  ) dut_small (
    .clock(clock), .reset_n(reset_n),
    .frame_valid(fv2), .frame_ready(fr2),
    .level(lvl2), .level_start(ls2), .level_ready(lr2),
    .win_valid(wv2), .win_ready(wr2),
    .win_row(row2), .win_col(col2),
    .frame_done(fd2), .busy(busy2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [31:0] l, input logic [31:0] r, input logic [31:0] c);
    return (l << 20) | (r << 10) | c;
  endfunction

  // Runs cycles (sampled at negedge) until frame_done, or until rst_cyc where reset is asserted
  task automatic run(input int max_cyc, input bit hold_fv, input int rst_cyc);
    bit stall = 0;
    logic [8:0] prow = '0, pcol = '0;
    done_cyc = -1;
    ls_cnt = 0;
    first_wv = -1;
    wq.delete();
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clock);
      if (!hold_fv) frame_valid = 1'b0;
      if (cyc == rst_cyc) begin
        reset_n = 1'b0;
        break;
      end
      if (stall && win_valid) begin
        chk("stall_row", 32'(win_row), 32'(prow));
        chk("stall_col", 32'(win_col), 32'(pcol));
      end
      if (win_valid && first_wv < 0) first_wv = cyc;
      if (level_start) begin
        ls_cnt++;
        lr_cnt = lr_delay;
        level_ready = 1'b0;
      end else if (lr_cnt > 0) begin
        lr_cnt--;
        level_ready = (lr_cnt == 0);
      end
      win_ready = bp_mode ? ((gcyc % 3) == 0) : 1'b1;
      gcyc++;
      if (win_valid && win_ready) wq.push_back(pack(32'(level), 32'(win_row), 32'(win_col)));
      stall = win_valid && !win_ready;
      prow = win_row;
      pcol = win_col;
      if (frame_done) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic chk_windows(input string tag);
    chk({tag, "_count"}, 32'(wq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk(tag, (i < wq.size()) ? wq[i] : 32'hffffffff, exp_win[i]);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_frame_ready"}, 32'(frame_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_row"}, 32'(win_row), 32'd0);
    chk({tag, "_col"}, 32'(win_col), 32'd0);
    chk({tag, "_level_start"}, 32'(level_start), 32'd0);
    chk({tag, "_win_valid"}, 32'(win_valid), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int ls_small, wv_small, fd_small;
    reset_n = 1'b0; frame_valid = 1'b0; level_ready = 1'b0; win_ready = 1'b0;
    fv2 = 1'b0; lr2 = 1'b1; wr2 = 1'b1;
    lr_cnt = 0; lr_delay = 2; gcyc = 0; bp_mode = 0;
    exp_win[0] = pack(0, 0, 0); exp_win[1] = pack(0, 0, 1); exp_win[2] = pack(0, 0, 2);
    exp_win[3] = pack(0, 1, 0); exp_win[4] = pack(0, 1, 1); exp_win[5] = pack(0, 1, 2);
    exp_win[6] = pack(1, 0, 0); exp_win[7] = pack(1, 0, 1);
    repeat (3) @(negedge clock);
    chk_reset_state("reset");
    reset_n = 1'b1;

    // Small-pyramid scan: L0 3x2 windows, L1 2x1, L2 skipped
    @(negedge clock);
    frame_valid = 1'b1;
    run(300, 0, 0);
    chk("t1_done_cycle", 32'(done_cyc), 32'd16);
    chk("t1_level_starts", 32'(ls_cnt), 32'd2);
    chk("t1_first_window", 32'(first_wv), 32'd4);
    chk_windows("t1_win");
    @(negedge clock);
    chk("t1_done_single", 32'(frame_done), 32'd0);
    chk("t1_ready_after", 32'(frame_ready), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Backpressure: win_ready 1 on / 2 off
    bp_mode = 1; gcyc = 0;
    frame_valid = 1'b1;
    run(300, 0, 0);
    chk("t2_done_seen", 32'(done_cyc > 0), 32'd1);
    chk("t2_level_starts", 32'(ls_cnt), 32'd2);
    chk_windows("t2_win");
    bp_mode = 0;

    // Slow integral unit: level_ready 50 cycles after each strobe
    @(negedge clock);
    lr_delay = 50;
    frame_valid = 1'b1;
    run(500, 0, 0);
    chk("t3_first_window", 32'(first_wv), 32'd52);
    chk("t3_level_starts", 32'(ls_cnt), 32'd2);
    chk("t3_done_cycle", 32'(done_cyc), 32'd112);
    chk_windows("t3_win");
    lr_delay = 2;

    // Reset during the third L0 window
    @(negedge clock);
    frame_valid = 1'b1;
    run(300, 0, 6);
    chk("t4_windows_before_reset", 32'(wq.size()), 32'd2);
    @(negedge clock);
    chk_reset_state("t4_after_reset");
    reset_n = 1'b1;
    frame_valid = 1'b1;
    run(300, 0, 0);
    chk("t4_restart_done_cycle", 32'(done_cyc), 32'd16);
    chk_windows("t4_restart_win");

    // Frame_valid held high: accepted again only once back in IDLE
    @(negedge clock);
    frame_valid = 1'b1;
    run(300, 1, 0);
    chk("t5_level_starts", 32'(ls_cnt), 32'd2);
    chk("t5_done_cycle", 32'(done_cyc), 32'd16);
    chk_windows("t5_win");
    @(negedge clock);
    chk("t5_ready_after_done", 32'(frame_ready), 32'd1);
    @(negedge clock);
    chk("t5_reaccept_strobe", 32'(level_start), 32'd1);
    chk("t5_reaccept_busy", 32'(busy), 32'd1);
    frame_valid = 1'b0;
    lr_cnt = 2; level_ready = 1'b0;
    run(300, 0, 0);
    chk("t5_second_frame_count", 32'(wq.size()), 32'd8);

    // Every level smaller than the window
    @(negedge clock);
    fv2 = 1'b1;
    ls_small = 0; wv_small = 0; fd_small = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      fv2 = 1'b0;
      if (ls2) ls_small++;
      if (wv2) wv_small++;
      if (fd2 && fd_small < 0) fd_small = c;
      if (c == 4) chk("t6_ready_after", 32'(fr2), 32'd1);
    end
    chk("t6_level_starts", 32'(ls_small), 32'd0);
    chk("t6_windows", 32'(wv_small), 32'd0);
    chk("t6_done_cycle", 32'(fd_small), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
